// File: rtl/regfile_port_ctrl_if.sv
// Request/response handshake bundle between a requester and regfile_port_ctrl.
// The controller side uses the slave modport; the requester uses master.
interface regfile_port_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rd_en;
    logic              req_wr_en;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;
    logic [ADDR_W-1:0] req_rd;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data_1;
    logic [DATA_W-1:0] rsp_data_2;

    modport master (
        output req_valid, req_rd_en, req_wr_en, req_rs, req_rt, req_rd, req_wdata,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data_1, rsp_data_2
    );

    modport slave (
        input  req_valid, req_rd_en, req_wr_en, req_rs, req_rt, req_rd, req_wdata,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data_1, rsp_data_2
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Sequences operand-read / result-write requests onto the MIPS register file
// pins: read first, then write, then hand captured operands back.
module regfile_port_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    regfile_port_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] rf_reg_read_1,
    output logic [ADDR_W-1:0] rf_reg_read_2,
    output logic [ADDR_W-1:0] rf_reg_write,
    output logic              rf_read_write,
    output logic [DATA_W-1:0] rf_in_data,
    input  logic [DATA_W-1:0] rf_out_data_1,
    input  logic [DATA_W-1:0] rf_out_data_2,
    output logic [7:0]        op_count
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] rs_q;
    logic [ADDR_W-1:0] rt_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_en_q;
    logic              wr_en_q;

    assign bus.req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rs_q           <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
            wdata_q        <= '0;
            rd_en_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data_1 <= '0;
            bus.rsp_data_2 <= '0;
            op_count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rs_q    <= bus.req_rs;
                        rt_q    <= bus.req_rt;
                        rd_q    <= bus.req_rd;
                        wdata_q <= bus.req_wdata;
                        rd_en_q <= bus.req_rd_en;
                        wr_en_q <= bus.req_wr_en;
                        if (bus.req_rd_en)
                            state <= READ;
                        else if (bus.req_wr_en)
                            state <= WRITE;
                        else
                            op_count <= op_count + 8'd1;
                    end
                end
                READ: begin
                    // Operands are captured before any write, so rs/rt == rd yields the old value.
                    bus.rsp_data_1 <= rf_out_data_1;
                    bus.rsp_data_2 <= rf_out_data_2;
                    if (wr_en_q) begin
                        state <= WRITE;
                    end else begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                    end
                end
                WRITE: begin
                    if (rd_en_q) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        op_count <= op_count + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pin drive is gated by rst so a reset during WRITE suppresses that write immediately.
    always_comb begin
        rf_reg_read_1 = '0;
        rf_reg_read_2 = '0;
        rf_reg_write  = '0;
        rf_in_data    = '0;
        rf_read_write = 1'b0;
        if (!rst) begin
            if (state == READ) begin
                rf_reg_read_1 = rs_q;
                rf_reg_read_2 = rt_q;
            end
            if (state == WRITE) begin
                rf_reg_write  = rd_q;
                rf_in_data    = wdata_q;
                rf_read_write = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl driving a behavioural 8 x 8-bit
// register file with combinational reads and clocked writes.
module tb_regfile_port_ctrl;
    logic       clk;
    logic       rst;
    logic [2:0] rf_reg_read_1;
    logic [2:0] rf_reg_read_2;
    logic [2:0] rf_reg_write;
    logic       rf_read_write;
    logic [7:0] rf_in_data;
    logic [7:0] rf_out_data_1;
    logic [7:0] rf_out_data_2;
    logic [7:0] op_count;
    logic [7:0] rf_mem [8];

    int compared;
    int mismatched;

    regfile_port_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    regfile_port_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .rf_reg_read_1 (rf_reg_read_1),
        .rf_reg_read_2 (rf_reg_read_2),
        .rf_reg_write  (rf_reg_write),
        .rf_read_write (rf_read_write),
        .rf_in_data    (rf_in_data),
        .rf_out_data_1 (rf_out_data_1),
        .rf_out_data_2 (rf_out_data_2),
        .op_count      (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_read_write)
            rf_mem[rf_reg_write] <= rf_in_data;
    end
    assign rf_out_data_1 = rf_mem[rf_reg_read_1];
    assign rf_out_data_2 = rf_mem[rf_reg_read_2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic v, input logic rd_en, input logic wr_en,
                             input logic [2:0] rs, input logic [2:0] rt,
                             input logic [2:0] rd, input logic [7:0] wdata);
        bus.req_valid = v;
        bus.req_rd_en = rd_en;
        bus.req_wr_en = wr_en;
        bus.req_rs    = rs;
        bus.req_rt    = rt;
        bus.req_rd    = rd;
        bus.req_wdata = wdata;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        tick();
        tick();
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data_1", {24'd0, bus.rsp_data_1}, 32'd0);
        check("rst_rsp_data_2", {24'd0, bus.rsp_data_2}, 32'd0);
        check("rst_op_count", {24'd0, op_count}, 32'd0);
        check("rst_rf_rw", {31'd0, rf_read_write}, 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Write-only chain r0..r7 = 11..88
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'(i), 8'(8'h11 * (i + 1)));
            check("wchain_ready", {31'd0, bus.req_ready}, 32'd1);
            tick();
            drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
            check("wchain_rw", {31'd0, rf_read_write}, 32'd1);
            check("wchain_addr", {29'd0, rf_reg_write}, 32'(i));
            check("wchain_data", {24'd0, rf_in_data}, 32'(8'h11 * (i + 1)));
            check("wchain_busy", {31'd0, bus.req_ready}, 32'd0);
            tick();
            check("wchain_rw_low", {31'd0, rf_read_write}, 32'd0);
            check("wchain_wr_addr_idle", {29'd0, rf_reg_write}, 32'd0);
            check("wchain_idle", {31'd0, bus.req_ready}, 32'd1);
        end
        check("wchain_op_count", {24'd0, op_count}, 32'd8);

        // Read-only rs=3, rt=7
        drive_req(1'b1, 1'b1, 1'b0, 3'd3, 3'd7, 3'd0, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        check("rd_c1_addr1", {29'd0, rf_reg_read_1}, 32'd3);
        check("rd_c1_addr2", {29'd0, rf_reg_read_2}, 32'd7);
        check("rd_c1_rw", {31'd0, rf_read_write}, 32'd0);
        check("rd_c1_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check("rd_c2_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rd_c2_data1", {24'd0, bus.rsp_data_1}, 32'h44);
        check("rd_c2_data2", {24'd0, bus.rsp_data_2}, 32'h88);
        check("rd_c2_rw", {31'd0, rf_read_write}, 32'd0);
        check("rd_c2_addr_idle", {29'd0, rf_reg_read_1}, 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rd_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rd_done_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rd_done_op_count", {24'd0, op_count}, 32'd9);

        // Read+write on r2: response must carry old value 33
        drive_req(1'b1, 1'b1, 1'b1, 3'd2, 3'd2, 3'd2, 8'hAB);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        check("rw_c1_rw", {31'd0, rf_read_write}, 32'd0);
        check("rw_c1_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check("rw_c2_rw", {31'd0, rf_read_write}, 32'd1);
        check("rw_c2_addr", {29'd0, rf_reg_write}, 32'd2);
        check("rw_c2_data", {24'd0, rf_in_data}, 32'hAB);
        check("rw_c2_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        check("rw_c3_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rw_c3_data1", {24'd0, bus.rsp_data_1}, 32'h33);
        check("rw_c3_data2", {24'd0, bus.rsp_data_2}, 32'h33);
        check("rw_c3_rw", {31'd0, rf_read_write}, 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rw_done_op_count", {24'd0, op_count}, 32'd10);

        // Read r2 back, then hold the response under backpressure
        drive_req(1'b1, 1'b1, 1'b0, 3'd2, 3'd2, 3'd0, 8'h00);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        tick();
        check("rb_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rb_data1", {24'd0, bus.rsp_data_1}, 32'hAB);
        drive_req(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 8'hEE);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_data1", {24'd0, bus.rsp_data_1}, 32'hAB);
            check("bp_data2", {24'd0, bus.rsp_data_2}, 32'hAB);
            check("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("bp_rw", {31'd0, rf_read_write}, 32'd0);
        end
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_rel_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_rel_ready", {31'd0, bus.req_ready}, 32'd1);
        check("bp_rel_op_count", {24'd0, op_count}, 32'd11);
        check("bp_r0_intact", {24'd0, rf_mem[0]}, 32'h11);

        // Reset asserted during the WRITE cycle of r5 <= FF
        drive_req(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 3'd5, 8'hFF);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        check("wrst_pre_rw", {31'd0, rf_read_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("wrst_rw_suppressed", {31'd0, rf_read_write}, 32'd0);
        check("wrst_ready_low", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("wrst_r5_kept", {24'd0, rf_mem[5]}, 32'h66);
        check("wrst_op_count", {24'd0, op_count}, 32'd0);
        check("wrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("wrst_rsp_data_1", {24'd0, bus.rsp_data_1}, 32'd0);
        check("wrst_rf_wr_addr", {29'd0, rf_reg_write}, 32'd0);
        check("wrst_rf_in_data", {24'd0, rf_in_data}, 32'd0);
        rst = 1'b0;
        tick();
        check("wrst_ready_back", {31'd0, bus.req_ready}, 32'd1);
        check("wrst_r5_still", {24'd0, rf_mem[5]}, 32'h66);

        // 256 back-to-back no-op requests
        drive_req(1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 8'h5A);
        for (int k = 0; k < 256; k++) begin
            tick();
            check("noop_count", {24'd0, op_count}, 32'((k + 1) % 256));
            check("noop_ready", {31'd0, bus.req_ready}, 32'd1);
            check("noop_rw", {31'd0, rf_read_write}, 32'd0);
        end
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
        tick();
        check("noop_wrapped", {24'd0, op_count}, 32'd0);
        check("noop_r3_intact", {24'd0, rf_mem[3]}, 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Initiator-side sequencer for the 8 x 8-bit register file in the single-cycle MIPS datapath. It accepts operand-read / result-write requests over a valid/ready handshake and drives the register file's address, data and read/write-select pins. It returns captured operands over a second valid/ready handshake. Ordering inside a request is read-then-write, and it never asserts write-select outside its single WRITE cycle.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 3, register address width (2^ADDR_W registers)

- clk  in  1  rising-edge clock, shared with register file
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_rd_en  in  1  read operands rs, rt
- req_wr_en  in  1  write req_wdata to rd
- req_rs, req_rt, req_rd  in  ADDR_W each  register addresses
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  operands available
- rsp_ready  in  1  consumer takes operands
- rsp_data_1, rsp_data_2  out  DATA_W  captured values of rs, rt
- rf_reg_read_1, rf_reg_read_2  out  ADDR_W  to register file read addresses
- rf_reg_write  out  ADDR_W  to register file write address
- rf_read_write  out  1  0 = read, 1 = write
- rf_in_data  out  DATA_W  to register file write data
- rf_out_data_1, rf_out_data_2  in  DATA_W  from register file; combinational read data
- op_count  out  8  completed-request counter

## Operation
- State machine states: IDLE, READ, WRITE, RESP. Reset state is IDLE.
- Accept: a request is accepted on a rising edge when req_valid && req_ready.
  - On accept, latch rs, rt, rd, wdata, rd_en and wr_en into internal registers.
- Transitions out of IDLE on accept:
  - rd_en=1: go to READ.
  - rd_en=0, wr_en=1: go to WRITE.
  - rd_en=0, wr_en=0: stay in IDLE. The request is a no-op and op_count increments.
- READ (1 cycle):
  - Drive rf_reg_read_1=rs, rf_reg_read_2=rt, rf_read_write=0.
  - At the end of the cycle, capture rf_out_data_1/2 into rsp_data_1/2.
  - Next state is WRITE if wr_en, else RESP.
- WRITE (1 cycle):
  - Drive rf_reg_write=rd, rf_in_data=wdata, rf_read_write=1.
  - Next state is RESP if rd_en, else IDLE with op_count incremented.
- RESP:
  - rsp_valid=1, with rsp_data stable.
  - On rsp_ready, go to IDLE and increment op_count.
- Read-before-write: if rs or rt equals rd, the response carries the old value, never wdata.
- Idle drive values: outside READ, rf_reg_read_* hold 0; outside WRITE, rf_reg_write=0, rf_in_data=0, rf_read_write=0.
- op_count wraps from 255 to 0.
- req_ready = (state==IDLE) && !rst. No request is accepted in READ, WRITE or RESP.

## Timing
- Reset values:
  - req_ready=0 while rst is high, 1 from the first cycle after rst is released.
  - rsp_valid=0, rsp_data_1/2=0, rf_* outputs all 0, op_count=0.
- rf_read_write = (state==WRITE) && !rst. A reset asserted during WRITE suppresses that write in the same cycle.
- Reset in any state returns to IDLE on the next edge, discarding the pending request and any pending response. Register file contents are untouched.
- Latency is counted from the acceptance edge (edge 0):
  - Read-only: READ in cycle 1; rsp_valid from cycle 2.
  - Read+write: READ in cycle 1, WRITE in cycle 2; rsp_valid from cycle 3.
  - Write-only: WRITE in cycle 1; req_ready high again in cycle 2.
- rsp_valid holds with stable data until rsp_ready is sampled high. It drops in the cycle after that edge, and req_ready rises in that same cycle.
- Minimum accept-to-accept spacing: read-only 3 cycles, read+write 4, write-only 2, no-op 1.

## Test plan
- Write-only chain: write 8'h11..8'h88 to r0..r7 (wr_en=1, rd_en=0).
  - Each rf_read_write pulse is exactly 1 cycle with matching rf_reg_write/rf_in_data.
  - op_count=8.
- Read after writes: rd_en=1, rs=3, rt=7.
  - rsp_valid 2 cycles after accept, rsp_data_1=8'h44, rsp_data_2=8'h88.
  - rf_read_write stays 0 throughout.
- Read+write same register: rs=rt=rd=2, wdata=8'hAB.
  - Response is 8'h33/8'h33, rsp_valid at cycle 3.
  - A following read of r2 returns 8'hAB.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid and rsp_data stay stable; req_ready stays 0; new req_valid is ignored.
  - Release: IDLE next cycle.
- Reset during WRITE (wr_en=1, rd=5, wdata=8'hFF): rst high in the WRITE cycle.
  - rf_read_write=0 in that cycle; r5 keeps 8'h66.
  - All outputs return to their reset values, and op_count returns to 0.
- No-op requests: 256 requests with rd_en=wr_en=0, back to back.
  - One accepted per cycle; op_count wraps to 0; no rf_read_write activity.
